// File: rtl/sdm_modulator.sv
// Second-order single-bit sigma-delta modulator: signed PCM in, pulse-density bit out.
// Both integrators saturate rather than wrap, so overdriven inputs degrade gracefully.
module sdm_modulator #(
    parameter int DAC_BW = 16,
    parameter int INT_W  = DAC_BW + 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DAC_BW-1:0] din,
    output logic                     dout
);

    localparam int SUM_W = INT_W + 2;

    localparam logic signed [SUM_W-1:0] FB_POS  = $signed(SUM_W'(1) << (DAC_BW - 1));
    localparam logic signed [SUM_W-1:0] FB_NEG  = -FB_POS;
    localparam logic signed [SUM_W-1:0] SAT_MAX = $signed((SUM_W'(1) << (INT_W - 1)) - SUM_W'(1));
    localparam logic signed [SUM_W-1:0] SAT_MIN = -$signed(SUM_W'(1) << (INT_W - 1));

    logic signed [INT_W-1:0] i1;
    logic signed [INT_W-1:0] i2;
    logic                    dout_q;

    logic                    q;
    logic signed [SUM_W-1:0] v;
    logic signed [SUM_W-1:0] x_ext;
    logic signed [SUM_W-1:0] i1_ext;
    logic signed [SUM_W-1:0] i2_ext;
    logic signed [SUM_W-1:0] i1_n_ext;
    logic signed [SUM_W-1:0] sum1;
    logic signed [SUM_W-1:0] sum2;
    logic signed [INT_W-1:0] i1_next;
    logic signed [INT_W-1:0] i2_next;

    function automatic logic signed [INT_W-1:0] sat(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] c;
        if (s > SAT_MAX)
            c = SAT_MAX;
        else if (s < SAT_MIN)
            c = SAT_MIN;
        else
            c = s;
        return $signed(c[INT_W-1:0]);
    endfunction

    always_comb begin
        // Quantiser looks only at registered state, so dout is one stage behind it.
        q        = ~i2[INT_W-1];
        v        = q ? FB_POS : FB_NEG;
        x_ext    = $signed({{(SUM_W-DAC_BW){din[DAC_BW-1]}}, din});
        i1_ext   = $signed({{(SUM_W-INT_W){i1[INT_W-1]}}, i1});
        i2_ext   = $signed({{(SUM_W-INT_W){i2[INT_W-1]}}, i2});
        sum1     = i1_ext + x_ext - v;
        i1_next  = sat(sum1);
        // Second integrator consumes the freshly updated first integrator.
        i1_n_ext = $signed({{(SUM_W-INT_W){i1_next[INT_W-1]}}, i1_next});
        sum2     = i2_ext + i1_n_ext - v;
        i2_next  = sat(sum2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1     <= '0;
            i2     <= '0;
            dout_q <= 1'b0;
        end else begin
            i1     <= i1_next;
            i2     <= i2_next;
            dout_q <= q;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_sdm_modulator.sv
// Bench for sdm_modulator: cycle-exact integer reference model plus density checks.
module tb_sdm_modulator;

    localparam int DAC_BW = 16;
    localparam int INT_W  = 22;
    localparam longint HALF = 32768;
    localparam longint SMAX = (longint'(1) << 21) - 1;
    localparam longint SMIN = -(longint'(1) << 21);

    logic                     clk;
    logic                     rst_n;
    logic signed [DAC_BW-1:0] din;
    logic                     dout;

    sdm_modulator #(.DAC_BW(DAC_BW), .INT_W(INT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference state
    longint m_i1, m_i2;
    int     m_dout;

    // per-window statistics
    int     mism, ones, max_run, run_len, last_bit, x_seen, first_bad;
    longint obs_min, obs_max;
    int     cyc;

    function automatic longint clamp(input longint s);
        if (s > SMAX) return SMAX;
        if (s < SMIN) return SMIN;
        return s;
    endfunction

    task automatic model_reset();
        m_i1 = 0; m_i2 = 0; m_dout = 0;
    endtask

    task automatic model_step(input int x);
        longint v, n1;
        v      = (m_i2 >= 0) ? HALF : -HALF;
        n1     = clamp(m_i1 + longint'(x) - v);
        m_i2   = clamp(m_i2 + n1 - v);
        m_i1   = n1;
        m_dout = (v > 0) ? 1 : 0;
    endtask

    task automatic clear_stats();
        mism = 0; ones = 0; max_run = 0; run_len = 0; last_bit = -1;
        first_bad = -1; obs_min = 0; obs_max = 0; cyc = 0;
    endtask

    // One clock: drive din, advance model, sample DUT 1 ns after the edge.
    task automatic tick(input int x);
        longint a1, a2;
        int b;
        din = DAC_BW'(x);
        @(posedge clk);
        model_step(x);
        #1;
        a1 = dut.i1;
        a2 = dut.i2;
        if ($isunknown(dout)) x_seen++;
        b = (dout === 1'b1) ? 1 : 0;
        if (b != m_dout || a1 != m_i1 || a2 != m_i2) begin
            mism++;
            if (first_bad < 0) first_bad = cyc;
        end
        ones += b;
        if (b == last_bit) run_len++; else run_len = 1;
        last_bit = b;
        if (run_len > max_run) max_run = run_len;
        if (a1 < obs_min) obs_min = a1;
        if (a2 < obs_min) obs_min = a2;
        if (a1 > obs_max) obs_max = a1;
        if (a2 > obs_max) obs_max = a2;
        cyc++;
    endtask

    task automatic do_reset(input int x);
        din   = DAC_BW'(x);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        longint a1, a2;
        din   = -16'sd16384;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a1 = dut.i1; a2 = dut.i2;
        n_checks++;
        if (dout !== 1'b0) $display("FAIL reset_dout got %b want 0", dout); else n_pass++;
        n_checks++;
        if (a1 !== 0) $display("FAIL reset_i1 got %0d want 0", a1); else n_pass++;
        n_checks++;
        if (a2 !== 0) $display("FAIL reset_i2 got %0d want 0", a2); else n_pass++;
        $display("test_reset: dout=%b i1=%0d i2=%0d", dout, a1, a2);
        model_reset();
    endtask

    // Checks the three documented post-reset edges for din = -16384.
    task automatic check_first_edges(input string tag);
        int     exp_d  [3] = '{1, 0, 0};
        longint exp_i1 [3] = '{-49152, -32768, -16384};
        longint exp_i2 [3] = '{-81920, -81920, -65536};
        longint a1, a2;
        for (int e = 0; e < 3; e++) begin
            tick(-16384);
            a1 = dut.i1; a2 = dut.i2;
            n_checks++;
            if (dout !== 1'(exp_d[e]))
                $display("FAIL %s_edge%0d_dout got %b want %0d", tag, e + 1, dout, exp_d[e]);
            else n_pass++;
            n_checks++;
            if (a1 != exp_i1[e])
                $display("FAIL %s_edge%0d_i1 got %0d want %0d", tag, e + 1, a1, exp_i1[e]);
            else n_pass++;
            n_checks++;
            if (a2 != exp_i2[e])
                $display("FAIL %s_edge%0d_i2 got %0d want %0d", tag, e + 1, a2, exp_i2[e]);
            else n_pass++;
            $display("%s edge %0d: dout=%b i1=%0d i2=%0d", tag, e + 1, dout, a1, a2);
        end
    endtask

    task automatic test_first_edges();
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        check_first_edges("first");
    endtask

    task automatic test_density(input string tag, input int x, input int settle, input int n,
                                input int lo, input int hi, input bit runs);
        clear_stats();
        repeat (settle) tick(x);
        ones = 0; max_run = 0; run_len = 0; last_bit = -1;
        repeat (n) tick(x);
        n_checks++;
        if (mism != 0) $display("FAIL %s_model mismatches %0d first at %0d want 0", tag, mism, first_bad);
        else n_pass++;
        n_checks++;
        if (ones < lo || ones > hi) $display("FAIL %s_density ones %0d want %0d..%0d", tag, ones, lo, hi);
        else n_pass++;
        if (runs) begin
            n_checks++;
            if (max_run > 2) $display("FAIL %s_runlen got %0d want <=2", tag, max_run);
            else n_pass++;
        end
        $display("%s: din=%0d ones=%0d/%0d max_run=%0d", tag, x, ones, n, max_run);
    endtask

    task automatic test_saturation();
        do_reset(-32768);
        clear_stats();
        repeat (10000) tick(-32768);
        n_checks++;
        if (mism != 0) $display("FAIL sat_model mismatches %0d first at %0d want 0", mism, first_bad);
        else n_pass++;
        n_checks++;
        if (obs_min < SMIN || obs_max > SMAX)
            $display("FAIL sat_bounds got %0d..%0d want %0d..%0d", obs_min, obs_max, SMIN, SMAX);
        else n_pass++;
        n_checks++;
        if (ones * 10 >= 10000) $display("FAIL sat_mostly_zero ones %0d want <1000", ones);
        else n_pass++;
        $display("saturation: ones=%0d range=%0d..%0d", ones, obs_min, obs_max);
    endtask

    task automatic test_async_reset();
        longint a1, a2;
        do_reset(0);
        clear_stats();
        repeat (37) tick(int'($urandom_range(0, 49152)) - 24576);
        #3;
        rst_n = 1'b0;
        #1;
        a1 = dut.i1; a2 = dut.i2;
        n_checks++;
        if (dout !== 1'b0 || a1 != 0 || a2 != 0)
            $display("FAIL async_reset got dout=%b i1=%0d i2=%0d want 0/0/0", dout, a1, a2);
        else n_pass++;
        $display("async_reset: dout=%b i1=%0d i2=%0d", dout, a1, a2);
        din = -16'sd16384;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_first_edges("async");
    endtask

    task automatic test_step();
        do_reset(0);
        clear_stats();
        repeat (128) tick(0);
        repeat (256) tick(16384);
        ones = 0;
        repeat (1024) tick(16384);
        n_checks++;
        if (mism != 0) $display("FAIL step_model mismatches %0d first at %0d want 0", mism, first_bad);
        else n_pass++;
        n_checks++;
        if (ones < 758 || ones > 778) $display("FAIL step_density ones %0d want 758..778", ones);
        else n_pass++;
        n_checks++;
        if (x_seen != 0) $display("FAIL no_x got %0d unknown samples want 0", x_seen);
        else n_pass++;
        $display("step: ones=%0d/1024 x_samples=%0d", ones, x_seen);
    endtask

    task automatic test_random();
        do_reset(0);
        clear_stats();
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 3) == 0)
                tick(int'($urandom_range(0, 65535)) - 32768);
            else
                tick(int'($urandom_range(0, 49152)) - 24576);
        end
        n_checks++;
        if (mism != 0) $display("FAIL random_model mismatches %0d first at %0d want 0", mism, first_bad);
        else n_pass++;
        $display("random: 2000 cycles mismatches=%0d", mism);
    endtask

    initial begin
        x_seen = 0;
        din    = '0;
        rst_n  = 1'b0;
        test_reset();
        test_first_edges();
        test_density("neg_half", -16384, 64, 4096, 1016, 1032, 1'b0);
        do_reset(0);
        test_density("zero", 0, 64, 4096, 2028, 2068, 1'b1);
        do_reset(24576);
        test_density("pos_3q", 24576, 64, 4096, 3543, 3625, 1'b0);
        test_saturation();
        test_async_reset();
        test_step();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
